// File: rtl/line_clipper_pkg.sv
// line_clipper_pkg: shared point type, outcode bits, clip FSM states and outcode helper
package line_clipper_pkg;

    localparam int POINT_W = 16;

    typedef struct packed {
        logic signed [POINT_W-1:0] x;
        logic signed [POINT_W-1:0] y;
    } point2d_t;

    localparam logic [3:0] OC_INSIDE = 4'b0000;
    localparam logic [3:0] OC_LEFT   = 4'b0001;
    localparam logic [3:0] OC_RIGHT  = 4'b0010;
    localparam logic [3:0] OC_BOTTOM = 4'b0100;
    localparam logic [3:0] OC_TOP    = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TEST,
        S_CALC,
        S_DIV,
        S_UPDATE,
        S_DONE
    } clip_state_t;

    function automatic logic [3:0] outcode(input point2d_t p, input int xmin, input int xmax,
                                           input int ymin, input int ymax);
        return ((p.x < xmin) ? OC_LEFT : (p.x > xmax) ? OC_RIGHT : OC_INSIDE) |
               ((p.y < ymin) ? OC_BOTTOM : (p.y > ymax) ? OC_TOP : OC_INSIDE);
    endfunction

endpackage

// File: rtl/line_clipper_divider.sv
// clip_divider: signed restoring divider, one quotient bit per cycle, truncating toward zero
module clip_divider #(
    parameter int W = 34
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [W-1:0] num,
    input  logic signed [W-1:0] den,
    output logic                done,
    output logic signed [W-1:0] quot
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  q;
    logic [W-1:0]  d;
    logic [W:0]    r;
    logic [W:0]    r2;
    logic [CW-1:0] cnt;
    logic          neg;
    logic          zero;
    logic          ge;

    // done marks the cycle the last bit is computed; quot is final from the next cycle on
    always_comb begin
        r2   = {r[W-1:0], q[W-1]};
        ge   = r2 >= {1'b0, d};
        done = cnt == CW'(1);
        quot = zero ? '0 : neg ? -$signed(q) : $signed(q);
    end

    // magnitudes are divided unsigned; the sign is reapplied on the way out
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            d    <= '0;
            r    <= '0;
            cnt  <= '0;
            neg  <= 1'b0;
            zero <= 1'b0;
        end else if (start) begin
            q    <= num[W-1] ? -num : num;
            d    <= den[W-1] ? -den : den;
            r    <= '0;
            cnt  <= CW'(W);
            neg  <= num[W-1] ^ den[W-1];
            zero <= den == '0;
        end else if (cnt != '0) begin
            r    <= ge ? r2 - {1'b0, d} : r2;
            q    <= {q[W-2:0], ge};
            cnt  <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/line_clipper.sv
// line_clipper: iterative Cohen-Sutherland clipper with valid/ready handshake
module line_clipper
    import line_clipper_pkg::*;
#(
    parameter int COORD_W  = POINT_W,
    parameter int XMIN     = 0,
    parameter int XMAX     = 640,
    parameter int YMIN     = 0,
    parameter int YMAX     = 480,
    parameter int MAX_ITER = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     in_valid,
    output logic     in_ready,
    input  point2d_t in_p0,
    input  point2d_t in_p1,
    output logic     out_valid,
    input  logic     out_ready,
    output point2d_t out_p0,
    output point2d_t out_p1,
    output logic     out_visible,
    output logic     busy
);

    localparam int DW = 2 * COORD_W + 2;
    localparam int IW = $clog2(MAX_ITER + 1);

    clip_state_t               state;
    clip_state_t               next;
    point2d_t                  p0;
    point2d_t                  p1;
    point2d_t                  np;
    logic                      vis;
    logic                      vis_n;
    logic [IW-1:0]             iter;
    logic [3:0]                c0;
    logic [3:0]                c1;
    logic [3:0]                c;
    logic                      mv1;
    logic                      vert;
    logic                      start;
    logic                      done;
    logic signed [COORD_W-1:0] e;
    logic signed [COORD_W-1:0] base;
    logic signed [COORD_W-1:0] nc;
    logic signed [COORD_W:0]   dx;
    logic signed [COORD_W:0]   dy;
    logic signed [COORD_W:0]   ed;
    logic signed [DW-1:0]      num;
    logic signed [DW-1:0]      den;
    logic signed [DW-1:0]      quot;

    // outcodes, edge selection and intersection operands; the line is always parametrised from p0
    always_comb begin
        c0   = outcode(p0, XMIN, XMAX, YMIN, YMAX);
        c1   = outcode(p1, XMIN, XMAX, YMIN, YMAX);
        mv1  = c0 == OC_INSIDE;
        c    = mv1 ? c1 : c0;
        vert = |(c & (OC_TOP | OC_BOTTOM));
        e    = |(c & OC_TOP)    ? COORD_W'(YMAX) :
               |(c & OC_BOTTOM) ? COORD_W'(YMIN) :
               |(c & OC_RIGHT)  ? COORD_W'(XMAX) : COORD_W'(XMIN);
        dx   = (COORD_W+1)'(p1.x) - (COORD_W+1)'(p0.x);
        dy   = (COORD_W+1)'(p1.y) - (COORD_W+1)'(p0.y);
        ed   = (COORD_W+1)'(e) - (COORD_W+1)'(vert ? p0.y : p0.x);
        num  = DW'(vert ? dx : dy) * DW'(ed);
        den  = DW'(vert ? dy : dx);
        base = vert ? p0.x : p0.y;
        nc   = base + quot[COORD_W-1:0];
        np   = vert ? '{x: nc, y: e} : '{x: e, y: nc};
    end

    // next-state, divider start and visibility decision
    always_comb begin
        next  = state;
        vis_n = vis;
        start = 1'b0;
        case (state)
            S_IDLE:   if (in_valid) begin
                next  = S_TEST;
                vis_n = 1'b0;
            end
            S_TEST: begin
                next  = ((c0 | c1) == OC_INSIDE || (c0 & c1) != OC_INSIDE || iter == IW'(MAX_ITER)) ? S_DONE : S_CALC;
                vis_n = (c0 | c1) == OC_INSIDE;
            end
            S_CALC: begin
                start = 1'b1;
                next  = S_DIV;
            end
            S_DIV:    next = done ? S_UPDATE : S_DIV;
            S_UPDATE: next = S_TEST;
            S_DONE:   next = out_ready ? S_IDLE : S_DONE;
            default:  next = S_IDLE;
        endcase
    end

    // state, endpoint and iteration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            p0    <= '0;
            p1    <= '0;
            vis   <= 1'b0;
            iter  <= '0;
        end else begin
            state <= next;
            vis   <= vis_n;
            if (state == S_IDLE && in_valid) begin
                p0   <= in_p0;
                p1   <= in_p1;
                iter <= '0;
            end
            if (state == S_UPDATE) begin
                if (mv1) p1 <= np;
                else p0 <= np;
                iter <= iter + 1'b1;
            end
        end
    end

    clip_divider #(.W(DW)) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .num   (num),
        .den   (den),
        .done  (done),
        .quot  (quot)
    );

    assign in_ready    = state == S_IDLE;
    assign out_valid   = state == S_DONE;
    assign busy        = state != S_IDLE;
    assign out_p0      = p0;
    assign out_p1      = p1;
    assign out_visible = vis;

endmodule
